spi_cmd_ctrl: RTL and testbench
===============================

// Module: spi_cmd_ctrl
// PURPOSE
//  Command sequencer behind spi_des. Buffers 32-bit words (one per parallel_rdy pulse), decodes
//  them, runs one register-bus access per command (req/ack, timeout) and returns read/error
//  responses on a valid/ready port to the serializer. Keeps saturating drop/error counters.
// PARAMETERS
//  CMD_DEPTH    4    command FIFO entries (power of 2, >=2)
//  ADDR_W       6    register address width (word bits [29:24])
//  TIMEOUT_CYC  255  cycles without bus_ack before a bus access is aborted (>=1)
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  parallel_rdy in   1       word strobe from spi_des, sync to clk; every high cycle = one word
//  parallel_in  in   32      command word, valid while parallel_rdy high
//  bus_req      out  1       register access request, held until bus_ack or timeout
//  bus_we       out  1       1 = write, 0 = read; stable while bus_req
//  bus_addr     out  ADDR_W  register address; stable while bus_req
//  bus_wdata    out  16      write data; stable while bus_req
//  bus_ack      in   1       single-cycle completion; ignored unless bus_req high
//  bus_rdata    in   16      read data, valid in bus_ack cycle
//  rsp_valid    out  1       response word available
//  rsp_data     out  32      {op[1:0], addr[5:0], rdata[15:0], status[7:0]}
//  rsp_ready    in   1       consumer accepts rsp_data when rsp_valid & rsp_ready
//  busy         out  1       FSM not IDLE or FIFO non-empty
//  drop_cnt     out  8       words lost to FIFO overflow, saturates at 8'hFF
//  err_cnt      out  8       timeouts + parity failures, saturates at 8'hFF
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, counters 0; rst_n asserted mid-access
//   aborts immediately (bus_req/rsp_valid drop asynchronously, no response emitted).
//  Word format: [31:30] op (00 NOP, 01 WRITE, 10 READ, 11 CLR), [29:24] addr,
//   [23:8] wdata, [7:0] tag (ignored; bit 0 is parity when enabled).
//  FIFO: push on parallel_rdy unless full; full & push & no pop -> word dropped, drop_cnt++.
//   Full with simultaneous pop -> push accepted. Pop only in IDLE.
//  FSM: IDLE -(!empty: pop, latch cmd)-> DECODE
//   DECODE: NOP->IDLE; CLR->counters<=0, IDLE; parity fail->status E2, RESP;
//           WRITE/READ->BUS
//   BUS: bus_req=1, timeout counter runs from 0. bus_ack: WRITE->IDLE, READ->RESP with
//        rdata=bus_rdata, status 00. Count==TIMEOUT_CYC-1 w/o ack: err_cnt++, WRITE->IDLE,
//        READ->RESP rdata 0, status E1. bus_req low the cycle after ack/timeout.
//   RESP: rsp_valid=1, rsp_data stable until rsp_ready; then IDLE.
//  Latency: parallel_rdy in cycle 0 -> FIFO non-empty cycle 1 -> DECODE cycle 2 ->
//   bus_req cycle 3. Earliest rsp_valid: cycle after bus_ack.
//  Writes produce no response. Counters saturate at 8'hFF; CLR in the same cycle as an
//   increment -> clear wins (counter 0).
// CONFIGURATION
//  SPI_CMD_PARITY_EN defined: bit 0 = even parity over [31:1]; mismatch -> no bus access,
//   err_cnt++, response status 8'hE2 for any op. Not defined: no check, bit 0 ignored,
//   status E2 never produced.
// STRUCTURE
//  spi_ctrl_pkg: op_e enum, state_e enum, STATUS_OK/E1/E2 localparams, word field
//   positions, pack_rsp() function.
//  Sub-module spi_cmd_fifo (CMD_DEPTH x 32, push/pop/full/empty, registered pointers);
//   FSM, timeout counter and stat counters in spi_cmd_ctrl.
// TESTING
//  1 WRITE 0x4_12_ABCD (addr 0x12), ack after 5 cyc -> bus_we=1, addr 0x12, wdata 0xABCD,
//    req 5 cyc, no rsp.
//  2 READ addr 0x05, bus_rdata 0x1234, rsp_ready low 3 cyc -> rsp_data 0x8512_3400 held
//    stable 3 cyc, then IDLE.
//  3 READ, bus_ack never -> req low after TIMEOUT_CYC cyc, err_cnt=1, rsp status 0xE1, rdata 0.
//  4 6 back-to-back words while bus stalled, CMD_DEPTH=4 -> 4 executed in order, drop_cnt=2.
//  5 CLR with drop_cnt=3, err_cnt=1 -> both 0; saturation: 300 drops -> drop_cnt=0xFF.
//  6 SPI_CMD_PARITY_EN, WRITE with bad parity -> no bus_req, err_cnt=1, status 0xE2;
//    rst_n low mid-BUS -> all outputs 0.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types, status codes and command-word field positions for the SPI command sequencer.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_BUS,
        S_RESP
    } state_e;

    localparam logic [7:0] STATUS_OK = 8'h00;
    localparam logic [7:0] STATUS_E1 = 8'hE1;
    localparam logic [7:0] STATUS_E2 = 8'hE2;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 30;
    localparam int unsigned ADDR_MSB  = 29;
    localparam int unsigned ADDR_LSB  = 24;
    localparam int unsigned WDATA_MSB = 23;
    localparam int unsigned WDATA_LSB = 8;

    function automatic logic [31:0] pack_rsp(input op_e op, input logic [5:0] addr,
                                             input logic [15:0] rdata, input logic [7:0] status);
        return {op, addr, rdata, status};
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Command word FIFO with registered read/write pointers; extra pointer bit separates full from empty.
module spi_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rptr[AW-1:0]];
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer: buffers SPI words, runs one register-bus access per command, returns responses.
// Optional build macro SPI_CMD_PARITY_EN enables even-parity checking of incoming words.
module spi_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CMD_DEPTH   = 4,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              parallel_rdy,
    input  logic [31:0]       parallel_in,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [15:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [15:0]       bus_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        err_cnt
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e        state, state_nxt;
    logic          pop, push, fifo_full, fifo_empty;
    logic [31:0]   fifo_rd_data;
    op_e           cmd_op;
    logic [5:0]    cmd_addr;
    logic [15:0]   cmd_wdata;
    logic          cmd_par_err, word_par_err;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic [15:0]   rsp_rdata;
    logic [7:0]    rsp_status;
    logic          err_inc, drop_inc, cnt_clr;
    logic          unused_tag;

    // A pop in the same cycle frees a slot, so a word arriving while full is still accepted.
    assign push     = parallel_rdy && (!fifo_full || pop);
    assign drop_inc = parallel_rdy && fifo_full && !pop;

    spi_cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(32)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (parallel_in),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef SPI_CMD_PARITY_EN
    assign word_par_err = ^fifo_rd_data;
`else
    assign word_par_err = 1'b0;
`endif
    assign unused_tag = ^fifo_rd_data[7:0];

    assign tmo_hit = (state == S_BUS) && !bus_ack && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_nxt = S_DECODE;
            S_DECODE: begin
                if (cmd_par_err)                                   state_nxt = S_RESP;
                else if (cmd_op == OP_WRITE || cmd_op == OP_READ)  state_nxt = S_BUS;
                else                                               state_nxt = S_IDLE;
            end
            S_BUS:    if (bus_ack || tmo_hit) state_nxt = (cmd_op == OP_READ) ? S_RESP : S_IDLE;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == S_IDLE) && !fifo_empty;
        bus_req   = (state == S_BUS);
        rsp_valid = (state == S_RESP);
        busy      = (state != S_IDLE) || !fifo_empty;
        cnt_clr   = (state == S_DECODE) && !cmd_par_err && (cmd_op == OP_CLR);
        err_inc   = tmo_hit || ((state == S_DECODE) && cmd_par_err);
    end

    assign bus_we    = (cmd_op == OP_WRITE);
    assign bus_addr  = ADDR_W'(cmd_addr);
    assign bus_wdata = cmd_wdata;
    assign rsp_data  = rsp_valid ? pack_rsp(cmd_op, cmd_addr, rsp_rdata, rsp_status) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_op      <= OP_NOP;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_par_err <= 1'b0;
            tmo_cnt     <= '0;
            rsp_rdata   <= '0;
            rsp_status  <= STATUS_OK;
        end else begin
            if (pop) begin
                cmd_op      <= op_e'(fifo_rd_data[OP_MSB:OP_LSB]);
                cmd_addr    <= fifo_rd_data[ADDR_MSB:ADDR_LSB];
                cmd_wdata   <= fifo_rd_data[WDATA_MSB:WDATA_LSB];
                cmd_par_err <= word_par_err;
            end
            tmo_cnt <= (state == S_BUS) ? tmo_cnt + TW'(1) : '0;
            if (state == S_DECODE && cmd_par_err) begin
                rsp_rdata  <= '0;
                rsp_status <= STATUS_E2;
            end else if (state == S_BUS && bus_ack) begin
                rsp_rdata  <= bus_rdata;
                rsp_status <= STATUS_OK;
            end else if (tmo_hit) begin
                rsp_rdata  <= '0;
                rsp_status <= STATUS_E1;
            end
        end
    end

    // Clear has priority over any increment landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else if (cnt_clr) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (err_inc  && err_cnt  != 8'hFF) err_cnt  <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: expected bus accesses and responses are queued, monitors compare.
module tb_spi_cmd_ctrl;

    localparam int unsigned TMO = 255;
    localparam logic [1:0] OPN = 2'b00, OPW = 2'b01, OPR = 2'b10, OPC = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        parallel_rdy = 1'b0;
    logic [31:0] parallel_in = '0;
    logic        bus_req, bus_we;
    logic [5:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready = 1'b1;
    logic        busy;
    logic [7:0]  drop_cnt, err_cnt;

    spi_cmd_ctrl #(.CMD_DEPTH(4), .ADDR_W(6), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .parallel_rdy(parallel_rdy), .parallel_in(parallel_in),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] op, input logic [5:0] a, input logic [15:0] d);
        logic [31:0] w;
        w = {op, a, d, 8'h00};
        w[0] = ^w[31:1];
        return w;
    endfunction

    typedef struct { logic we; logic [5:0] addr; logic [15:0] wdata; int len; } bus_t;
    bus_t        bus_q[$];
    logic [31:0] rsp_q[$];

    task automatic exp_bus(input logic we, input logic [5:0] a, input logic [15:0] d, input int len);
        bus_t e;
        e.we = we; e.addr = a; e.wdata = d; e.len = len;
        bus_q.push_back(e);
    endtask

    // Bus responder: ack in the ack_delay-th cycle of bus_req, or never.
    int  ack_delay = 5;
    bit  ack_never = 1'b0;
    int  ack_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n || !bus_req) begin
            ack_cnt = 0;
            bus_ack = 1'b0;
        end else begin
            ack_cnt++;
            bus_ack = !ack_never && (ack_cnt == ack_delay);
        end
    end

    // Bus monitor: fields against the queued access every req cycle, req length at the fall.
    bus_t cur;
    bit   in_req = 1'b0;
    int   req_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_req = 1'b0;
            req_len = 0;
        end else if (bus_req) begin
            if (!in_req) begin
                in_req = 1'b1;
                req_len = 0;
                if (bus_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL bus_unexpected: got access addr 0x%02h expected none", bus_addr);
                    cur.we = bus_we; cur.addr = bus_addr; cur.wdata = bus_wdata; cur.len = 0;
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            req_len++;
            check("bus_we", 32'(bus_we), 32'(cur.we));
            check("bus_addr", 32'(bus_addr), 32'(cur.addr));
            check("bus_wdata", 32'(bus_wdata), 32'(cur.wdata));
        end else if (in_req) begin
            in_req = 1'b0;
            if (cur.len != 0) check("bus_req_len", 32'(req_len), 32'(cur.len));
        end
    end

    // Response monitor: data must match the queue head every valid cycle; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_unexpected: got 0x%08h expected none", rsp_data);
            end else begin
                check("rsp_data", rsp_data, rsp_q[0]);
                if (rsp_ready) void'(rsp_q.pop_front());
            end
        end
    end

    task automatic put(input logic [31:0] w);
        parallel_rdy = 1'b1;
        parallel_in  = w;
        @(posedge clk); #1;
    endtask

    task automatic put_end();
        parallel_rdy = 1'b0;
        parallel_in  = '0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!bus_req && n < budget) begin @(posedge clk); #1; n++; end
        check("wait_bus_req", 32'(bus_req), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin @(posedge clk); #1; n++; end
        check("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin @(posedge clk); #1; n++; end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk); #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: write, ack in 5th req cycle, latency to bus_req is 3 cycles
        ack_delay = 5;
        exp_bus(1'b1, 6'h12, 16'hABCD, 5);
        put(mk(OPW, 6'h12, 16'hABCD));
        put_end();
        check("lat_c1_busy", 32'(busy), 32'd1);
        check("lat_c1_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        check("lat_c2_req", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        check("lat_c3_req", 32'(bus_req), 32'd1);
        wait_idle("t1_idle", 50);

        // 2: read with back-pressure on the response port
        rsp_ready = 1'b0;
        ack_delay = 2;
        bus_rdata = 16'h1234;
        exp_bus(1'b0, 6'h05, 16'h0000, 2);
        rsp_q.push_back(32'h8512_3400);
        put(mk(OPR, 6'h05, 16'h0000));
        put_end();
        wait_valid(50);
        repeat (3) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t2_idle_after_accept", 32'(busy), 32'd0);

        // 3: read timeout
        ack_never = 1'b1;
        bus_rdata = 16'h5A5A;
        exp_bus(1'b0, 6'h2A, 16'h0000, TMO);
        rsp_q.push_back(32'hAA00_00E1);
        put(mk(OPR, 6'h2A, 16'h0000));
        put_end();
        wait_idle("t3_idle", TMO + 50);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        ack_never = 1'b0;

        // 4: overflow while the bus is stalled
        ack_delay = 30;
        exp_bus(1'b1, 6'h01, 16'h1111, 30);
        put(mk(OPW, 6'h01, 16'h1111));
        put_end();
        wait_req(10);
        for (int i = 0; i < 6; i++) put(mk(OPW, 6'(16 + i), 16'(16'h2000 + i)));
        put_end();
        for (int i = 0; i < 4; i++) exp_bus(1'b1, 6'(16 + i), 16'(16'h2000 + i), 30);
        check("t4_drop_cnt", 32'(drop_cnt), 32'd2);
        wait_idle("t4_idle", 400);

        exp_bus(1'b1, 6'h02, 16'h2222, 30);
        put(mk(OPW, 6'h02, 16'h2222));
        put_end();
        wait_req(10);
        for (int i = 0; i < 5; i++) put(mk(OPW, 6'(24 + i), 16'(16'h2100 + i)));
        put_end();
        for (int i = 0; i < 4; i++) exp_bus(1'b1, 6'(24 + i), 16'(16'h2100 + i), 30);
        wait_idle("t4b_idle", 400);
        check("t5_drop_pre", 32'(drop_cnt), 32'd3);
        check("t5_err_pre", 32'(err_cnt), 32'd1);

        // 5: clear, then 300 drops saturate
        put(mk(OPC, 6'h00, 16'h0000));
        put_end();
        wait_idle("t5_clr_idle", 20);
        check("t5_drop_clr", 32'(drop_cnt), 32'd0);
        check("t5_err_clr", 32'(err_cnt), 32'd0);
        ack_delay = 200;
        for (int r = 0; r < 2; r++) begin
            exp_bus(1'b1, 6'(48 + r), 16'h3000, 200);
            put(mk(OPW, 6'(48 + r), 16'h3000));
            put_end();
            wait_req(10);
            for (int i = 0; i < 154; i++) put(mk(OPN, 6'h00, 16'h0000));
            put_end();
            wait_idle("t5_sat_idle", 400);
        end
        check("t5_drop_sat", 32'(drop_cnt), 32'hFF);
        check("t5_err_sat", 32'(err_cnt), 32'd0);

        // 6: word with a wrong parity bit
        ack_delay = 3;
`ifdef SPI_CMD_PARITY_EN
        rsp_q.push_back(32'h4900_00E2);
        put(mk(OPW, 6'h09, 16'hC0DE) ^ 32'd1);
        put_end();
        wait_idle("t6_par_idle", 20);
        check("t6_par_err_cnt", 32'(err_cnt), 32'd1);
`else
        exp_bus(1'b1, 6'h09, 16'hC0DE, 3);
        put(mk(OPW, 6'h09, 16'hC0DE) ^ 32'd1);
        put_end();
        wait_idle("t6_nopar_idle", 20);
        check("t6_nopar_err_cnt", 32'(err_cnt), 32'd0);
`endif

        // 6: reset in the middle of a bus access
        ack_never = 1'b1;
        exp_bus(1'b0, 6'h3F, 16'h0000, 0);
        put(mk(OPR, 6'h3F, 16'h0000));
        put_end();
        wait_req(10);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus_req", 32'(bus_req), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_bus_addr", 32'(bus_addr), 32'd0);
        check("mid_rst_bus_wdata", 32'(bus_wdata), 32'd0);
        check("mid_rst_rsp_data", rsp_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_never = 1'b0;

        // recovery read after reset
        ack_delay = 4;
        bus_rdata = 16'hBEEF;
        exp_bus(1'b0, 6'h3F, 16'h0000, 4);
        rsp_q.push_back(32'hBFBE_EF00);
        put(mk(OPR, 6'h3F, 16'h0000));
        put_end();
        wait_idle("rec_idle", 50);

        repeat (3) @(posedge clk); #1;
        check("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        check("end_bus_q_empty", 32'(bus_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
